// File: rtl/rstmgr_multi.sv
// Multi-domain reset manager: synchronised POR, per-domain stretched release
// chained in domain order, and a sticky reset-cause register.
//
// state | meaning
// Hold  | domain held in reset, waiting for request low and parent in Run
// Wait  | stretch counter running before release
// Run   | domain out of reset
module rstmgr_multi #(
  parameter int unsigned           NumDomains    = 3,
  parameter int unsigned           StretchCycles = 4,
  parameter int unsigned           SyncStages    = 2,
  parameter logic [NumDomains-1:0] NdmMask       = {NumDomains{1'b1}}
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ndmreset_i,
  input  logic [NumDomains-1:0] sw_rst_req_i,
  input  logic                  cause_clr_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  rst_done_o,
  output logic [2:0]            rst_cause_o
);

  localparam int unsigned     CntW   = $clog2(StretchCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StretchCycles - 1);

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StWait = 2'd1,
    StRun  = 2'd2
  } state_e;

  logic [SyncStages-1:0] sync_q;
  logic                  por_ok;
  logic [NumDomains-1:0] req;
  logic [NumDomains-1:0] in_run;
  logic                  done_q;
  logic [2:0]            cause_q;
  logic [2:0]            cause_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end
  end

  assign por_ok = sync_q[SyncStages-1];
  assign req    = {NumDomains{~por_ok}}
                | ({NumDomains{ndmreset_i}} & NdmMask)
                | sw_rst_req_i;

  for (genvar i = 0; i < NumDomains; i++) begin : g_dom
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            run_q;
    logic            parent_run;

    if (i == 0) begin : g_first
      assign parent_run = 1'b1;
    end else begin : g_chain
      assign parent_run = in_run[i-1];
    end

    // A parent dropping out of Run only matters before the child reaches Run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= StHold;
        cnt_q   <= '0;
        run_q   <= 1'b0;
      end else begin
        case (state_q)
          StHold: begin
            if (!req[i] && parent_run) begin
              state_q <= StWait;
              cnt_q   <= '0;
            end
          end
          StWait: begin
            if (req[i] || !parent_run) begin
              state_q <= StHold;
            end else if (cnt_q == CntMax) begin
              state_q <= StRun;
              run_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StRun: begin
            if (req[i]) begin
              state_q <= StHold;
              run_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= StHold;
            run_q   <= 1'b0;
          end
        endcase
      end
    end

    assign in_run[i] = (state_q == StRun);
    assign rst_no[i] = run_q;
  end

  // Set wins over clear; the por bit is only ever set by rst_ni itself.
  assign cause_d = (cause_q & {3{~cause_clr_i}})
                 | {|sw_rst_req_i, ndmreset_i & (|NdmMask), 1'b0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q  <= 1'b0;
      cause_q <= 3'b001;
    end else begin
      done_q  <= &in_run;
      cause_q <= cause_d;
    end
  end

  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rstmgr_multi.sv
// Self-checking bench for rstmgr_multi (3 domains, stretch 4, 2 sync stages,
// ndm reaching domains 1 and 2 only).
module tb_rstmgr_multi;

  localparam int N = 3;

  logic         clk_i        = 1'b0;
  logic         rst_ni       = 1'b0;
  logic         ndmreset_i   = 1'b0;
  logic [N-1:0] sw_rst_req_i = '0;
  logic         cause_clr_i  = 1'b0;
  logic [N-1:0] rst_no;
  logic         rst_done_o;
  logic [2:0]   rst_cause_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] no;
    logic       done;
    logic [2:0] cause;
  } exp_t;

  typedef struct {
    logic       ndm;
    logic [2:0] sw;
    logic       clr;
    logic [2:0] no;
    logic       done;
    logic [2:0] cause;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[16];

  rstmgr_multi #(
    .NumDomains   (N),
    .StretchCycles(4),
    .SyncStages   (2),
    .NdmMask      (3'b110)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ndmreset_i  (ndmreset_i),
    .sw_rst_req_i(sw_rst_req_i),
    .cause_clr_i (cause_clr_i),
    .rst_no      (rst_no),
    .rst_done_o  (rst_done_o),
    .rst_cause_o (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input exp_t e);
    n_cmp++;
    if (rst_no !== e.no || rst_done_o !== e.done || rst_cause_o !== e.cause) begin
      n_err++;
      $display("FAIL %s: got rst_no=%b done=%b cause=%b, required rst_no=%b done=%b cause=%b",
               tag, rst_no, rst_done_o, rst_cause_o, e.no, e.done, e.cause);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic cyc(input string tag, input logic ndm, input logic [2:0] sw, input logic clr,
                     input logic [2:0] no, input logic done, input logic [2:0] cause);
    exp_t e;
    ndmreset_i   = ndm;
    sw_rst_req_i = sw;
    cause_clr_i  = clr;
    e.no = no; e.done = done; e.cause = cause;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, required one entry", tag);
    end else begin
      check(tag, sb_q.pop_front());
    end
  endtask

  // Edges counted from rst_ni deassertion: domain i releases at 2 + (i+1)*5.
  task automatic por_seq(input string tag, input int n);
    logic [2:0] no;
    for (int e = 1; e <= n; e++) begin
      for (int d = 0; d < N; d++) no[d] = (e >= 2 + (d + 1) * 5);
      cyc($sformatf("%s_e%0d", tag, e), 1'b0, 3'b000, 1'b0, no, (e >= 18), 3'b001);
    end
  endtask

  initial begin
    exp_t ex;
    logic [2:0] no;

    // sw pulse on domain 1, then clear racing a sw[2] set, then a bare clear.
    tbl[0]  = '{1'b0, 3'b010, 1'b0, 3'b101, 1'b1, 3'b101};
    tbl[1]  = '{1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 3'b101};
    tbl[2]  = '{1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 3'b101};
    tbl[3]  = '{1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 3'b101};
    tbl[4]  = '{1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 3'b101};
    tbl[5]  = '{1'b0, 3'b000, 1'b0, 3'b111, 1'b0, 3'b101};
    tbl[6]  = '{1'b0, 3'b000, 1'b0, 3'b111, 1'b1, 3'b101};
    tbl[7]  = '{1'b0, 3'b100, 1'b1, 3'b011, 1'b1, 3'b100};
    tbl[8]  = '{1'b0, 3'b000, 1'b0, 3'b011, 1'b0, 3'b100};
    tbl[9]  = '{1'b0, 3'b000, 1'b0, 3'b011, 1'b0, 3'b100};
    tbl[10] = '{1'b0, 3'b000, 1'b0, 3'b011, 1'b0, 3'b100};
    tbl[11] = '{1'b0, 3'b000, 1'b0, 3'b011, 1'b0, 3'b100};
    tbl[12] = '{1'b0, 3'b000, 1'b0, 3'b111, 1'b0, 3'b100};
    tbl[13] = '{1'b0, 3'b000, 1'b0, 3'b111, 1'b1, 3'b100};
    tbl[14] = '{1'b0, 3'b000, 1'b1, 3'b111, 1'b1, 3'b000};
    tbl[15] = '{1'b0, 3'b000, 1'b0, 3'b111, 1'b1, 3'b000};

    @(posedge clk_i); #1;
    ex = '{3'b000, 1'b0, 3'b001};
    check("reset_state", ex);
    @(posedge clk_i); #1;
    check("reset_state_held", ex);

    rst_ni = 1'b1;
    por_seq("por", 20);

    for (int i = 0; i < 16; i++)
      cyc($sformatf("vec%0d", i), tbl[i].ndm, tbl[i].sw, tbl[i].clr,
          tbl[i].no, tbl[i].done, tbl[i].cause);

    // ndm for 10 cycles: domain 0 masked, 1 and 2 release 5 edges apart.
    for (int e = 1; e <= 22; e++) begin
      no = {1'(e >= 20), 1'(e >= 15), 1'b1};
      cyc($sformatf("ndm_e%0d", e), (e <= 10), 3'b000, 1'b0, no,
          (e == 1) || (e >= 21), 3'b010);
    end

    // Domain 1 in Wait when domain 0 is knocked back to Hold.
    for (int e = 1; e <= 15; e++) begin
      no = {1'b1, 1'(e >= 13), 1'(!(e >= 3 && e < 8))};
      cyc($sformatf("parent_e%0d", e), 1'b0,
          (e == 1) ? 3'b010 : ((e == 3) ? 3'b001 : 3'b000), 1'b0,
          no, (e == 1) || (e >= 14), 3'b110);
    end

    // Async assertion from Run with a pending cause: everything back to POR state.
    #2 rst_ni = 1'b0;
    #1 check("async_from_run", '{3'b000, 1'b0, 3'b001});
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    por_seq("por2", 10);
    #2 rst_ni = 1'b0;
    #1 check("async_mid_seq", '{3'b000, 1'b0, 3'b001});
    cyc("mid_seq_held", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'b001);
    rst_ni = 1'b1;
    por_seq("por3", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
